mem_dump_reader: RTL and testbench
==================================

MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter HOLD_CYCLES, default 50000000, auto-mode display time per word, in clocks.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 start  in  1  raw key level; a rising edge requests a scan.
REQ-007 stop  in  1  raw key level; a rising edge aborts the scan.
REQ-008 step  in  1  raw key level; a rising edge advances one word in manual mode.
REQ-009 auto  in  1  1 = timer advance, 0 = step advance; sampled only in HOLD.
REQ-010 rd  out  1  memory read strobe.
REQ-011 address  out  ADDR_W  memory address.
REQ-012 dataOut  in  DATA_W  memory read data, valid the cycle after rd.
REQ-013 curData  out  DATA_W  last captured word.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 done  out  1  one-cycle pulse at scan completion.
REQ-016 hexAddr, hexHi, hexLo  out  8 each  active-low 7-segment digits for address[3:0], curData[7:4], curData[3:0]; bit 7 (dp) is always 1.

Function
REQ-017 start, stop and step SHALL each pass through a 2-flop synchronizer followed by a registered rising-edge detector.
REQ-018 FSM states SHALL be IDLE, ISSUE, CAPTURE, HOLD and FINISH.
REQ-019 IDLE -> ISSUE on a start edge, with address cleared to 0.
REQ-020 rd SHALL be 1 only in ISSUE, for exactly one cycle per word, and is first asserted 3 clock edges after start is first sampled high.
REQ-021 ISSUE -> CAPTURE; in CAPTURE, curData loads dataOut and the hold counter clears.
REQ-022 CAPTURE -> HOLD.
REQ-023 HOLD with auto=1 SHALL leave after HOLD_CYCLES clocks.
REQ-024 HOLD with auto=0 SHALL leave on a step edge.
REQ-025 HOLD exit: address increments and the FSM goes to ISSUE, or to FINISH if address = 2^ADDR_W-1.
REQ-026 FINISH SHALL pulse done for one cycle and return to IDLE; address holds its last value.
REQ-027 A stop edge in any non-IDLE state SHALL force IDLE on the next edge, with rd=0 and no done pulse.
REQ-028 A start edge while busy SHALL be ignored.
REQ-029 Simultaneous start and stop edges in IDLE: stop wins and the FSM stays in IDLE.
REQ-030 Step edges outside HOLD, or in HOLD with auto=1, SHALL be ignored.
REQ-031 The hex decoder SHALL be combinational, covering 0-F (e.g. 0 -> 8'hC0, F -> 8'h8E).
REQ-032 The hex digits SHALL be blanked (8'hFF) while in IDLE before the first scan since reset; after a scan they keep showing the last word.

Reset
REQ-033 Reset low SHALL force: state IDLE, rd=0, address=0, curData=0, busy=0, done=0, hold counter 0, synchronizers 0, hex digits 8'hFF.
REQ-034 Reset asserted mid-scan SHALL take effect immediately, with no completing read.

Configuration
REQ-035 Macro MEM_DUMP_WRAP_EN: when defined, HOLD exit at the last address wraps address to 0 and goes to ISSUE; done pulses at each wrap; the scan ends only by stop or reset.
REQ-036 Without MEM_DUMP_WRAP_EN, the scan is single-pass per REQ-025/026.

Verification (bench: HOLD_CYCLES=4, model memory with 1-cycle latency, mem[i]=8'h10+i)
REQ-037 Auto single pass: auto=1, start pulse -> 16 rd pulses at addresses 0..15, each 7 cycles apart; curData ends at 8'h1F; one done pulse; busy falls together with done.
REQ-038 Manual: auto=0, start, then 3 step edges -> address=3, curData=8'h13, hexAddr=8'hB0, hexHi=8'hF9, hexLo=8'hB0, busy=1.
REQ-039 Stop in HOLD at address 5 -> IDLE the next cycle, no done, curData=8'h15 retained.
REQ-040 Reset low while rd=1 -> rd=0, address=0 and hex digits 8'hFF in the same cycle; after release, no activity until start.
REQ-041 Start edge while busy at address 7 -> no restart; scan completes at 15 with a single done.
REQ-042 MEM_DUMP_WRAP_EN defined, auto=1: after address 15 the next rd is at address 0, done pulses once per wrap, and busy stays 1 until stop.

Source files
------------

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: scans a memory word by word and shows address/data on 7-segment digits.
// Define MEM_DUMP_WRAP_EN to make the scan wrap to address 0 forever instead of ending at the last word.
module mem_dump_reader #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              auto_mode,
  output logic              rd,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] cur_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        hex_addr,
  output logic [7:0]        hex_hi,
  output logic [7:0]        hex_lo
);
`ifdef MEM_DUMP_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_CYCLES);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, HOLD, FINISH} state_t;
  state_t state, next;
  logic [2:0] sync0, sync1, prev, edges;
  logic [CNT_W-1:0] cnt;
  logic shown, hold_exit, last;
  // edges bit order: {step, stop, start}
  assign edges = sync1 & ~prev;
  assign last = &address;
  assign hold_exit = (state == HOLD) && (auto_mode ? cnt >= HOLD_CNT : edges[2]);
  assign rd = state == ISSUE;
  assign busy = state != IDLE;
  always_comb begin
    next = state;
    if (state != IDLE && edges[1]) next = IDLE;
    else
      case (state)
        IDLE:    next = (edges[0] && !edges[1]) ? ISSUE : IDLE;
        ISSUE:   next = CAPTURE;
        CAPTURE: next = HOLD;
        HOLD:    next = hold_exit ? ((last && !WRAP) ? FINISH : ISSUE) : HOLD;
        default: next = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0    <= '0;
      sync1    <= '0;
      prev     <= '0;
      state    <= IDLE;
      address  <= '0;
      cur_data <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      shown    <= 1'b0;
    end else begin
      sync0    <= {step, stop, start};
      sync1    <= sync0;
      prev     <= sync1;
      state    <= next;
      address  <= (state == IDLE && next == ISSUE) ? '0 :
                  (hold_exit && next == ISSUE) ? address + 1'b1 : address;
      cur_data <= (state == CAPTURE) ? data_out : cur_data;
      cnt      <= (state == CAPTURE) ? '0 :
                  (state == HOLD && auto_mode && cnt < HOLD_CNT) ? cnt + 1'b1 : cnt;
      done     <= hold_exit && last && next != IDLE;
      shown    <= shown | (state == IDLE && next == ISSUE);
    end
  end
  function automatic logic [7:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
  endfunction
  assign hex_addr = shown ? seg(address[3:0]) : 8'hFF;
  assign hex_hi   = shown ? seg(cur_data[7:4]) : 8'hFF;
  assign hex_lo   = shown ? seg(cur_data[3:0]) : 8'hFF;
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: scoreboard bench for mem_dump_reader with HOLD_CYCLES=4 and mem[i]=8'h10+i.
module tb_mem_dump_reader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, step = 1'b0, auto_mode = 1'b0;
  logic rd, busy, done;
  logic [3:0] address;
  logic [7:0] data_out = 8'h00, cur_data, hex_addr, hex_hi, hex_lo;
  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;
  always @(posedge clk) if (rd) data_out <= 8'h10 + {4'h0, address};

  mem_dump_reader #(.ADDR_W(4), .DATA_W(8), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step), .auto_mode(auto_mode),
    .rd(rd), .address(address), .data_out(data_out), .cur_data(cur_data), .busy(busy), .done(done),
    .hex_addr(hex_addr), .hex_hi(hex_hi), .hex_lo(hex_lo)
  );

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; auto_mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd, busy, done, address, cur_data} !== 15'h0) begin
      failures++; $display("FAIL reset_ctrl got=%h exp=0", {rd, busy, done, address, cur_data});
    end
    checks++;
    if ({hex_addr, hex_hi, hex_lo} !== 24'hFFFFFF) begin
      failures++; $display("FAIL reset_hex got=%h exp=ffffff", {hex_addr, hex_hi, hex_lo});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({rd, busy, hex_addr} !== 10'h0FF) begin
      failures++; $display("FAIL idle_after_reset got=%h exp=0ff", {rd, busy, hex_addr});
    end
  endtask

  task automatic test_manual();
    logic [7:0] e;
    auto_mode = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if ({busy, address, cur_data, hex_addr, hex_hi, hex_lo} !== {1'b1, 4'h0, 8'h10, 8'hC0, 8'hF9, 8'hC0}) begin
      failures++;
      $display("FAIL manual_first got=%h exp=%h", {busy, address, cur_data, hex_addr, hex_hi, hex_lo},
               {1'b1, 4'h0, 8'h10, 8'hC0, 8'hF9, 8'hC0});
    end
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      step = 1'b1;
      repeat (2) @(negedge clk);
      step = 1'b0;
      repeat (8) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (cur_data !== e || address !== e[3:0]) begin
        failures++; $display("FAIL manual_step%0d got=%h/%h exp=%h/%h", i, address, cur_data, e[3:0], e);
      end
    end
    checks++;
    if ({busy, hex_addr, hex_hi, hex_lo} !== {1'b1, 8'hB0, 8'hF9, 8'hB0}) begin
      failures++; $display("FAIL manual_hex got=%h exp=%h", {busy, hex_addr, hex_hi, hex_lo}, {1'b1, 8'hB0, 8'hF9, 8'hB0});
    end
  endtask

  task automatic test_stop();
    logic [7:0] e;
    bit done_seen = 1'b0;
    for (int i = 4; i <= 5; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      step = 1'b1;
      repeat (2) @(negedge clk);
      step = 1'b0;
      repeat (8) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (cur_data !== e || address !== e[3:0]) begin
        failures++; $display("FAIL stop_step%0d got=%h/%h exp=%h/%h", i, address, cur_data, e[3:0], e);
      end
    end
    stop = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL stop_early got=%b exp=1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL stop_idle got=%b exp=0", busy); end
    stop = 1'b0;
    repeat (6) begin
      @(negedge clk);
      done_seen |= done;
    end
    checks++;
    if ({done_seen, busy, address, cur_data, hex_lo} !== {2'b00, 4'h5, 8'h15, 8'h92}) begin
      failures++;
      $display("FAIL stop_retain got=%h exp=%h", {done_seen, busy, address, cur_data, hex_lo}, {2'b00, 4'h5, 8'h15, 8'h92});
    end
  endtask

`ifndef MEM_DUMP_WRAP_EN
  task automatic test_auto();
    int last = -1, dones = 0;
    bit prev_done = 1'b0;
    logic [7:0] e;
    auto_mode = 1'b1;
    for (int k = 0; k < 16; k++) exp_q.push_back(8'(k));
    start = 1'b1;
    for (int cyc = 1; cyc <= 130; cyc++) begin
      @(negedge clk);
      if (cyc == 3) start = 1'b0;
      if (rd) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL auto_rd_extra addr=%h cyc=%0d", address, cyc);
        end else begin
          e = exp_q.pop_front();
          if (address !== e[3:0]) begin failures++; $display("FAIL auto_rd_addr got=%h exp=%h", address, e[3:0]); end
        end
        checks++;
        if ((last < 0) ? (cyc != 3) : (cyc - last != 7)) begin
          failures++; $display("FAIL auto_rd_spacing got=%0d exp=%0d", (last < 0) ? cyc : cyc - last, (last < 0) ? 3 : 7);
        end
        last = cyc;
      end
      if (done) begin
        dones++;
        checks++;
        if ({busy, address} !== 5'h1F) begin failures++; $display("FAIL auto_done_state got=%h exp=1f", {busy, address}); end
      end
      if (prev_done) begin
        checks++;
        if ({busy, done} !== 2'b00) begin failures++; $display("FAIL auto_busy_fall got=%b exp=00", {busy, done}); end
      end
      prev_done = done;
    end
    checks++;
    if (exp_q.size() != 0 || dones != 1) begin
      failures++; $display("FAIL auto_totals left=%0d dones=%0d exp=0/1", exp_q.size(), dones);
    end
    checks++;
    if ({busy, cur_data, hex_addr, hex_hi, hex_lo} !== {1'b0, 8'h1F, 8'h8E, 8'hF9, 8'h8E}) begin
      failures++;
      $display("FAIL auto_final got=%h exp=%h", {busy, cur_data, hex_addr, hex_hi, hex_lo}, {1'b0, 8'h1F, 8'h8E, 8'hF9, 8'h8E});
    end
    exp_q.delete();
  endtask

  task automatic test_busy_start();
    int dones = 0;
    logic [7:0] e;
    auto_mode = 1'b1;
    for (int k = 0; k < 16; k++) exp_q.push_back(8'(k));
    start = 1'b1;
    for (int cyc = 1; cyc <= 130; cyc++) begin
      @(negedge clk);
      if (cyc == 3 || cyc == 55) start = 1'b0;
      if (cyc == 52) begin
        checks++;
        if ({rd, address} !== 5'h17) begin failures++; $display("FAIL busy_start_pos got=%h exp=17", {rd, address}); end
        start = 1'b1;
      end
      if (rd) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL busy_start_rd_extra addr=%h cyc=%0d", address, cyc);
        end else begin
          e = exp_q.pop_front();
          if (address !== e[3:0]) begin failures++; $display("FAIL busy_start_rd_addr got=%h exp=%h", address, e[3:0]); end
        end
      end
      if (done) dones++;
    end
    checks++;
    if (exp_q.size() != 0 || dones != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL busy_start_totals left=%0d dones=%0d busy=%b exp=0/1/0", exp_q.size(), dones, busy);
    end
    exp_q.delete();
  endtask
`else
  task automatic test_wrap();
    int dones = 0;
    bit busy_low = 1'b0;
    logic [7:0] e;
    auto_mode = 1'b1;
    for (int k = 0; k <= 32; k++) exp_q.push_back(8'(k % 16));
    start = 1'b1;
    for (int cyc = 1; cyc <= 230; cyc++) begin
      @(negedge clk);
      if (cyc == 3) start = 1'b0;
      if (cyc >= 3 && !busy) busy_low = 1'b1;
      if (rd) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL wrap_rd_extra addr=%h cyc=%0d", address, cyc);
        end else begin
          e = exp_q.pop_front();
          if (address !== e[3:0]) begin failures++; $display("FAIL wrap_rd_addr got=%h exp=%h", address, e[3:0]); end
        end
      end
      if (done) begin
        dones++;
        checks++;
        if ({rd, address} !== 5'h10) begin failures++; $display("FAIL wrap_done_pos got=%h exp=10", {rd, address}); end
      end
    end
    checks++;
    if (exp_q.size() != 0 || dones != 2 || busy_low) begin
      failures++; $display("FAIL wrap_totals left=%0d dones=%0d busy_low=%b exp=0/2/0", exp_q.size(), dones, busy_low);
    end
    stop = 1'b1;
    repeat (4) @(negedge clk);
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL wrap_stop got=%b exp=0", busy); end
    exp_q.delete();
    repeat (12) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    bit found = 1'b0, activity = 1'b0;
    auto_mode = 1'b1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 3) start = 1'b0;
      if (rd && address == 4'h2) begin found = 1'b1; break; end
    end
    start = 1'b0;
    checks++;
    if (!found) begin failures++; $display("FAIL reset_mid_timeout got=0 exp=1"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd, busy, address, hex_addr, hex_hi, hex_lo} !== {6'h00, 24'hFFFFFF}) begin
      failures++;
      $display("FAIL reset_mid_async got=%h exp=%h", {rd, busy, address, hex_addr, hex_hi, hex_lo}, {6'h00, 24'hFFFFFF});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      activity |= rd | busy | done;
    end
    checks++;
    if ({activity, cur_data, hex_lo} !== {1'b0, 8'h00, 8'hFF}) begin
      failures++; $display("FAIL reset_mid_quiet got=%h exp=%h", {activity, cur_data, hex_lo}, {1'b0, 8'h00, 8'hFF});
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_stop();
`ifdef MEM_DUMP_WRAP_EN
    test_wrap();
`else
    test_auto();
    repeat (5) @(negedge clk);
    test_busy_start();
    repeat (5) @(negedge clk);
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
